// File: rtl/in_fifo_chain.sv
// Avalon-ST ingress with a framing checker feeding a linear chain of NODES inline FIFO stages.
// Optional per-stage occupancy high-watermark when IN_FIFO_CHAIN_STATS_EN is defined.
module in_fifo_chain #(
  parameter int NODES    = 8,
  parameter int DATA_W   = 128,
  parameter int CH_W     = 2,
  parameter int EMPTY_W  = 4,
  parameter int DEPTH    = 16,
  parameter int XOFF_LVL = 12,
  parameter int XON_LVL  = 8
) (
  input  logic                       clock,
  input  logic                       sclr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [EMPTY_W-1:0]         st_empty,
  input  logic                       st_sop,
  input  logic                       st_eop,
  input  logic [CH_W-1:0]            st_channel,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [NODES-1:0]           pnode_ready,
  output logic [NODES*DATA_W-1:0]    pnode_data,
  output logic [NODES*EMPTY_W-1:0]   pnode_empty,
  output logic [NODES*CH_W-1:0]      pnode_channel,
  output logic [NODES-1:0]           pnode_sop,
  output logic [NODES-1:0]           pnode_eop,
  output logic [NODES-1:0]           pnode_valid,
  output logic                       xoff,
  output logic [15:0]                err_count
`ifdef IN_FIFO_CHAIN_STATS_EN
  ,
  input  logic                       hwm_clr,
  output logic [NODES*($clog2(DEPTH)+1)-1:0] hwm
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = CH_W + EMPTY_W + 2 + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_CNT = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] XOFF_CNT   = CNT_W'(XOFF_LVL);
  localparam logic [CNT_W-1:0] XON_CNT    = CNT_W'(XON_LVL);

  typedef enum logic {IDLE, INPKT} frame_t;

  frame_t            r_frame;
  logic [15:0]       r_errCount;
  logic              r_xoff;
  logic              w_accept;
  logic              w_frameOk;
  logic              w_push0;
  logic [CNT_W-1:0]  w_count   [NODES];
  logic [WORD_W-1:0] w_outWord [NODES];
  logic [NODES-1:0]  w_outValid;

  assign st_ready  = (w_count[0] < FULL_CNT);
  assign w_accept  = st_valid & st_ready;
  assign w_frameOk = (r_frame == IDLE) ? st_sop : !st_sop;
  assign w_push0   = w_accept & w_frameOk;

  // Malformed words are consumed from the stream but never reach stage 0.
  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_frame    <= IDLE;
      r_errCount <= '0;
    end else if (w_accept) begin
      if (!w_frameOk) begin
        if (r_errCount != 16'hFFFF)
          r_errCount <= r_errCount + 16'd1;
      end else if (st_eop) begin
        r_frame <= IDLE;
      end else begin
        r_frame <= INPKT;
      end
    end
  end

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr)
      r_xoff <= 1'b0;
    else if (w_count[0] >= XOFF_CNT)
      r_xoff <= 1'b1;
    else if (w_count[0] <= XON_CNT)
      r_xoff <= 1'b0;
  end

  assign xoff        = r_xoff;
  assign err_count   = r_errCount;
  assign pnode_valid = w_outValid;

  for (genvar i = 0; i < NODES; i++) begin : g_stage
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_oValid;
    logic [WORD_W-1:0] r_oWord;
    logic              w_push;
    logic              w_pop;
    logic              w_downOk;
    logic [WORD_W-1:0] w_wrWord;

    if (i == 0) begin : g_head
      assign w_push   = w_push0;
      assign w_wrWord = {st_channel, st_empty, st_sop, st_eop, st_data};
    end else begin : g_body
      assign w_push   = w_outValid[i-1];
      assign w_wrWord = w_outWord[i-1];
    end

    // Two slots of headroom downstream absorb the word already sitting in r_oWord.
    if (i == NODES - 1) begin : g_tail
      assign w_downOk = 1'b1;
    end else begin : g_mid
      assign w_downOk = (w_count[i+1] <= MARGIN_CNT);
    end

    assign w_pop = (w_count[i] != '0) & pnode_ready[i] & w_downOk;

    always_ff @(posedge clock) begin
      if (w_push)
        r_mem[r_wrPtr] <= w_wrWord;
    end

    always_ff @(posedge clock or posedge sclr) begin
      if (sclr) begin
        r_wrPtr  <= '0;
        r_rdPtr  <= '0;
        r_count  <= '0;
        r_oValid <= 1'b0;
        r_oWord  <= '0;
      end else begin
        if (w_push)
          r_wrPtr <= r_wrPtr + PTR_W'(1);
        if (w_pop)
          r_rdPtr <= r_rdPtr + PTR_W'(1);
        if (w_push && !w_pop)
          r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop)
          r_count <= r_count - CNT_W'(1);
        r_oValid <= w_pop;
        if (w_pop)
          r_oWord <= r_mem[r_rdPtr];
      end
    end

    assign w_count[i]    = r_count;
    assign w_outWord[i]  = r_oWord;
    assign w_outValid[i] = r_oValid;

    assign pnode_data[i*DATA_W +: DATA_W]      = r_oWord[DATA_W-1:0];
    assign pnode_eop[i]                        = r_oWord[DATA_W];
    assign pnode_sop[i]                        = r_oWord[DATA_W+1];
    assign pnode_empty[i*EMPTY_W +: EMPTY_W]   = r_oWord[DATA_W+2 +: EMPTY_W];
    assign pnode_channel[i*CH_W +: CH_W]       = r_oWord[DATA_W+2+EMPTY_W +: CH_W];

`ifdef IN_FIFO_CHAIN_STATS_EN
    logic [CNT_W-1:0] r_hwm;

    always_ff @(posedge clock or posedge sclr) begin
      if (sclr)
        r_hwm <= '0;
      else if (hwm_clr)
        r_hwm <= r_count;
      else if (r_count > r_hwm)
        r_hwm <= r_count;
    end

    assign hwm[i*CNT_W +: CNT_W] = r_hwm;
`endif
  end

endmodule

// File: tb/tb_in_fifo_chain.sv
// Scoreboard bench for in_fifo_chain: directed packets, per-node expected queues, flow-control checks.
// Exercises the watermark outputs when IN_FIFO_CHAIN_STATS_EN is defined.
module tb_in_fifo_chain;

  localparam int NODES   = 8;
  localparam int DATA_W  = 128;
  localparam int CH_W    = 2;
  localparam int EMPTY_W = 4;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 5;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
    logic [DATA_W-1:0]  data;
  } word_t;

  logic                     clock;
  logic                     sclr;
  logic [DATA_W-1:0]        st_data;
  logic [EMPTY_W-1:0]       st_empty;
  logic                     st_sop;
  logic                     st_eop;
  logic [CH_W-1:0]          st_channel;
  logic                     st_valid;
  logic                     st_ready;
  logic [NODES-1:0]         pnode_ready;
  logic [NODES*DATA_W-1:0]  pnode_data;
  logic [NODES*EMPTY_W-1:0] pnode_empty;
  logic [NODES*CH_W-1:0]    pnode_channel;
  logic [NODES-1:0]         pnode_sop;
  logic [NODES-1:0]         pnode_eop;
  logic [NODES-1:0]         pnode_valid;
  logic                     xoff;
  logic [15:0]              err_count;
`ifdef IN_FIFO_CHAIN_STATS_EN
  logic                     hwm_clr;
  logic [NODES*CNT_W-1:0]   hwm;
`endif

  word_t expQ [NODES][$];
  int    lat0[$];
  int    lat7[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    lastAcceptCyc = 0;
  bit    latCapture = 0;

  in_fifo_chain dut (
    .clock(clock), .sclr(sclr),
    .st_data(st_data), .st_empty(st_empty), .st_sop(st_sop), .st_eop(st_eop),
    .st_channel(st_channel), .st_valid(st_valid), .st_ready(st_ready),
    .pnode_ready(pnode_ready), .pnode_data(pnode_data), .pnode_empty(pnode_empty),
    .pnode_channel(pnode_channel), .pnode_sop(pnode_sop), .pnode_eop(pnode_eop),
    .pnode_valid(pnode_valid), .xoff(xoff), .err_count(err_count)
`ifdef IN_FIFO_CHAIN_STATS_EN
    , .hwm_clr(hwm_clr), .hwm(hwm)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every valid strobe on any node must match the head of that node's queue.
  always @(negedge clock) begin
    word_t got;
    word_t exp;
    if (!sclr) begin
      for (int n = 0; n < NODES; n++) begin
        if (pnode_valid[n]) begin
          got.data  = pnode_data[n*DATA_W +: DATA_W];
          got.ch    = pnode_channel[n*CH_W +: CH_W];
          got.empty = pnode_empty[n*EMPTY_W +: EMPTY_W];
          got.sop   = pnode_sop[n];
          got.eop   = pnode_eop[n];
          checks++;
          if (latCapture && n == 0) lat0.push_back(cyc);
          if (latCapture && n == 7) lat7.push_back(cyc);
          if (expQ[n].size() == 0) begin
            errors++;
            $display("[TB] FAIL node%0d unexpected word: got data=%0h ch=%0d sop=%0b eop=%0b, required no output",
                     n, got.data, got.ch, got.sop, got.eop);
          end else begin
            exp = expQ[n].pop_front();
            if (got !== exp) begin
              errors++;
              $display("[TB] FAIL node%0d word: got data=%0h ch=%0d empty=%0d sop=%0b eop=%0b, required data=%0h ch=%0d empty=%0d sop=%0b eop=%0b",
                       n, got.data, got.ch, got.empty, got.sop, got.eop,
                       exp.data, exp.ch, exp.empty, exp.sop, exp.eop);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int pending();
    int s = 0;
    for (int n = 0; n < NODES; n++) s += expQ[n].size();
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Drive one word and hold it until accepted; expected copies go to every node queue when kept.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                               input logic [CH_W-1:0] ch, input logic [EMPTY_W-1:0] em, input bit keep);
    int waitCnt;
    word_t w;
    @(negedge clock);
    st_data = d; st_sop = sop; st_eop = eop; st_channel = ch; st_empty = em; st_valid = 1'b1;
    waitCnt = 0;
    while (!st_ready && waitCnt < 300) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!st_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: got st_ready=0 for data=%0h, required 1", d);
      st_valid = 1'b0;
    end else begin
      lastAcceptCyc = cyc;
      if (keep) begin
        w.data = d; w.ch = ch; w.empty = em; w.sop = sop; w.eop = eop;
        for (int n = 0; n < NODES; n++) expQ[n].push_back(w);
      end
      @(posedge clock);
      #1 st_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (pending() != 0 && n < 600) begin
      @(posedge clock);
      n++;
    end
    repeat (4) @(posedge clock);
    #1 checkOutput(name, pending(), 0);
  endtask

  initial begin
    int firstCyc;
    sclr = 1'b1; st_valid = 1'b0; st_data = '0; st_sop = 1'b0; st_eop = 1'b0;
    st_channel = '0; st_empty = '0; pnode_ready = '1;
`ifdef IN_FIFO_CHAIN_STATS_EN
    hwm_clr = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1 sclr = 1'b0;
    #1;
    checkOutput("reset pnode_valid", 32'(pnode_valid), 0);
    checkOutput("reset pnode_data", 32'(|pnode_data), 0);
    checkOutput("reset xoff", 32'(xoff), 0);
    checkOutput("reset err_count", 32'(err_count), 0);
    checkOutput("reset st_ready", 32'(st_ready), 1);

    $display("[TB] single 3-word packet latency");
    latCapture = 1;
    applyStimulus(128'h100, 1'b1, 1'b0, 2'd2, 4'd0, 1'b1);
    firstCyc = lastAcceptCyc;
    applyStimulus(128'h101, 1'b0, 1'b0, 2'd2, 4'd0, 1'b1);
    applyStimulus(128'h102, 1'b0, 1'b1, 2'd2, 4'd5, 1'b1);
    waitDrain("drain packet1");
    latCapture = 0;
    checkOutput("node0 count", lat0.size(), 3);
    checkOutput("node7 count", lat7.size(), 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("node0 latency w%0d", k), lat0.size() > k ? lat0[k] - firstCyc : -1, 2 + k);
      checkOutput($sformatf("node7 latency w%0d", k), lat7.size() > k ? lat7[k] - firstCyc : -1, 16 + k);
    end
    checkOutput("err_count after packet1", 32'(err_count), 0);

    $display("[TB] backpressure on node 0 and xoff hysteresis");
    @(negedge clock) pnode_ready = 8'hFE;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(128'h200 + 128'(k), k == 1, k == 16, 2'd1, 4'd0, 1'b1);
      if (k == 12) checkOutput("xoff at count 12", 32'(xoff), 0);
      if (k == 13) checkOutput("xoff after count 12", 32'(xoff), 1);
      if (k == 16) begin
        checkOutput("st_ready full", 32'(st_ready), 0);
        checkOutput("xoff full", 32'(xoff), 1);
      end
    end
    @(negedge clock) pnode_ready = '1;
    for (int j = 1; j <= 9; j++) begin
      @(posedge clock);
      #1;
      if (j == 8) checkOutput("xoff held at count 8", 32'(xoff), 1);
      if (j == 9) checkOutput("xoff cleared", 32'(xoff), 0);
    end
    waitDrain("drain backpressure");

    $display("[TB] framing errors");
    applyStimulus(128'h300, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0);
    applyStimulus(128'h301, 1'b1, 1'b0, 2'd3, 4'd0, 1'b1);
    applyStimulus(128'h302, 1'b0, 1'b0, 2'd3, 4'd0, 1'b1);
    applyStimulus(128'h303, 1'b1, 1'b0, 2'd3, 4'd0, 1'b0);
    applyStimulus(128'h304, 1'b0, 1'b1, 2'd3, 4'd2, 1'b1);
    checkOutput("err_count after drops", 32'(err_count), 2);
    waitDrain("drain framing");

    $display("[TB] node 3 stall under continuous input");
    fork
      begin
        @(negedge clock) pnode_ready[3] = 1'b0;
        repeat (50) @(posedge clock);
        @(negedge clock) pnode_ready[3] = 1'b1;
      end
      begin
        for (int k = 0; k < 60; k++)
          applyStimulus(128'h400 + 128'(k), (k % 4) == 0, (k % 4) == 3, 2'(k), 4'(k), 1'b1);
      end
    join
    waitDrain("drain stall");
    checkOutput("err_count after stall", 32'(err_count), 2);

    $display("[TB] asynchronous reset mid-packet");
    applyStimulus(128'h500, 1'b1, 1'b0, 2'd1, 4'd0, 1'b1);
    applyStimulus(128'h501, 1'b0, 1'b0, 2'd1, 4'd0, 1'b1);
    @(posedge clock);
    #1 sclr = 1'b1;
    for (int n = 0; n < NODES; n++) expQ[n].delete();
    #1;
    checkOutput("sclr pnode_valid", 32'(pnode_valid), 0);
    checkOutput("sclr pnode_data", 32'(|pnode_data), 0);
    checkOutput("sclr xoff", 32'(xoff), 0);
    checkOutput("sclr err_count", 32'(err_count), 0);
    #4 sclr = 1'b0;
    repeat (6) @(posedge clock);
    #1 checkOutput("no valid after sclr", 32'(pnode_valid), 0);
    applyStimulus(128'h600, 1'b1, 1'b1, 2'd0, 4'd7, 1'b1);
    waitDrain("drain after sclr");
    checkOutput("err_count after sclr packet", 32'(err_count), 0);

`ifdef IN_FIFO_CHAIN_STATS_EN
    $display("[TB] high-watermark");
    @(negedge clock) hwm_clr = 1'b1;
    @(negedge clock) hwm_clr = 1'b0;
    pnode_ready = 8'hFD;
    for (int k = 0; k < 10; k++)
      applyStimulus(128'h700 + 128'(k), k == 0, k == 9, 2'd2, 4'd0, 1'b1);
    repeat (8) @(posedge clock);
    #1 checkOutput("hwm stage1", 32'(hwm[1*CNT_W +: CNT_W]), 10);
    @(negedge clock) pnode_ready = '1;
    waitDrain("drain hwm");
    @(negedge clock) hwm_clr = 1'b1;
    @(negedge clock) hwm_clr = 1'b0;
    #1 checkOutput("hwm stage1 cleared", 32'(hwm[1*CNT_W +: CNT_W]), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
